sum_checker: RTL
================

# sum_checker

Sequential result checker that sits on the far side of the 4-bit `adder` in the test environment. It accepts one vector per handshake: operands `a`/`b` plus the adder's `sum`/`carry_out`. It recomputes the expected `{carry, sum}`, keeps pass/fail counts and a sticky error flag, and emits a one-cycle report pulse when the stimulus side signals end of test.

## Interface
- `WIDTH`, default 4: operand and sum width.
- `CNT_W`, default 16: width of the pass and fail counters.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: a vector is presented on `a`, `b`, `sum` and `carry_out`.
- `in_ready` out 1: checker can accept a vector.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `sum` in WIDTH: DUT sum under check.
- `carry_out` in 1: DUT carry under check.
- `done` in 1: end-of-test request, level-sampled.
- `pass_count` out CNT_W: number of vectors that matched.
- `fail_count` out CNT_W: number of vectors that mismatched.
- `error` out 1: sticky; set on the first mismatch.
- `report_valid` out 1: one-cycle pulse; counters are final.
- `fail_a`, `fail_b`, `fail_sum` out WIDTH, and `fail_carry` out 1: first failing vector (see Configuration).

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - CHECK: `in_ready`=0.
  - REPORT: `in_ready`=0.
- IDLE transitions:
  - `in_valid`=1 registers `a`, `b`, `sum`, `carry_out` → CHECK. This is an accept.
  - `done`=1 and `in_valid`=0 → REPORT.
  - `in_valid` and `done` both high → accept wins; `done` is re-sampled on the next IDLE cycle.
- CHECK:
  - Expected value is `{1'b0,a} + {1'b0,b}`, computed at WIDTH+1 bits with no truncation.
  - Match compares against `{carry_out,sum}`.
  - On match, `pass_count` increments; otherwise `fail_count` increments and `error` sets.
  - → IDLE unconditionally.
- REPORT: `report_valid`=1 for exactly this cycle → IDLE. Counters and `error` are retained, and further vectors keep accumulating.
- Counters saturate at 2^CNT_W−1; they never wrap.
- `error` clears only on `reset`.
- Inputs outside an accept cycle are ignored, including X on the data lines while `in_valid`=0.

## Timing
- Reset values:
  - State IDLE, so `in_ready`=1 out of reset.
  - `pass_count`=0, `fail_count`=0, `error`=0, `report_valid`=0.
  - All `fail_*` = 0.
- Accept is at edge N. Counter and `error` update are visible after edge N+1. `in_ready` returns to 1 after edge N+1.
- Throughput: one vector per two cycles. Back-to-back `in_valid` is accepted every other cycle; the source must hold `in_valid` and data until `in_ready`=1.
- `done` seen in IDLE at edge N → `report_valid` high from edge N until edge N+1.
- `reset` asserted mid-CHECK or mid-REPORT: all outputs take their reset values immediately (asynchronous). Any in-flight vector is discarded uncounted.
- Reset deassertion is synchronized externally; the first accept is possible on the first edge after deassertion.

## Configuration
- Macro: `SUM_CHECK_FAIL_CAPTURE_EN`.
- Defined:
  - On the first mismatch (`error` 0→1), the registered vector is latched into `fail_a`, `fail_b`, `fail_sum` and `fail_carry` in the same edge as the `fail_count` update.
  - Later mismatches do not overwrite the latch.
  - The latch clears on `reset`.
- Undefined:
  - The `fail_*` ports still exist and are tied to 0.
  - No capture registers are synthesized.
  - All other behaviour is identical.

## Test plan
- Good vectors: after reset, apply (1,2,3,0), (5,6,11,0), (15,1,0,1), (10,5,15,0) with correct DUT values, then pulse `done`.
  - Required: `pass_count`=4, `fail_count`=0, `error`=0.
  - Required: exactly one `report_valid` cycle.
- Mismatch: vector (15,1,sum=0,carry=0).
  - Required: `fail_count`=1 and `error`=1 after the CHECK edge.
  - Required with the macro: `fail_a`=15, `fail_b`=1, `fail_sum`=0, `fail_carry`=0.
  - Required: a following bad vector (3,3,7,0) leaves the `fail_*` outputs unchanged.
- Handshake: hold `in_valid`=1 with distinct vectors, advancing data only on accept.
  - Required: `in_ready` toggles 1,0,1,0.
  - Required: accepts every second cycle; counts equal the number of vectors sent.
- Simultaneous events: `in_valid`=1 and `done`=1 in the same IDLE cycle.
  - Required: the vector is counted first; `report_valid` pulses two edges later with the count already including it.
- Saturation: with `CNT_W`=2, apply 5 good vectors.
  - Required: `pass_count` stops at 3.
- Reset mid-operation: assert `reset` the cycle after an accept.
  - Required: all counters, `error` and `fail_*` = 0 immediately; `in_ready`=1; the vector is not counted.

Source files
------------

// File: rtl/sum_checker.sv
// ----------------------------------------------------------------------------
// sum_checker
//
// Result checker for a WIDTH-bit adder. One vector (a, b, sum, carry_out) is
// accepted per valid/ready handshake and checked on the following cycle
// against {1'b0,a} + {1'b0,b}. Pass and fail counts saturate instead of
// wrapping. A sticky error flag records any mismatch. A sampled `done` in
// IDLE produces a one-cycle report pulse.
//
// Optional feature macro: SUM_CHECK_FAIL_CAPTURE_EN
//   defined   : the first failing vector is latched onto fail_a/b/sum/carry
//   undefined : fail_* ports are tied to zero and no capture registers exist
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   in_valid      in   vector present on a/b/sum/carry_out
//   in_ready      out  checker can accept a vector (IDLE)
//   a, b          in   adder operands
//   sum           in   adder sum under check
//   carry_out     in   adder carry under check
//   done          in   end-of-test request, level-sampled in IDLE
//   pass_count    out  matching vectors (saturating)
//   fail_count    out  mismatching vectors (saturating)
//   error         out  sticky mismatch flag
//   report_valid  out  one-cycle pulse, counters final
//   fail_a/b/sum  out  first failing vector operands and sum
//   fail_carry    out  first failing vector carry
// ----------------------------------------------------------------------------
module sum_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry_out,
    input  logic             done,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             error,
    output logic             report_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_sum,
    output logic             fail_carry
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [WIDTH:0]   expected;
    logic             match;
    logic             check_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An accept takes priority over done. done stays level-sampled and is
    // seen again on the next IDLE cycle.
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        report_valid = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = CHECK;
                end else if (done) begin
                    state_next = REPORT;
                end
            end
            CHECK: begin
                state_next = IDLE;
            end
            REPORT: begin
                report_valid = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            sum_reg   <= sum;
            carry_reg <= carry_out;
        end
    end

    // The reference sum is one bit wider so the carry is never lost.
    assign expected  = {1'b0, a_reg} + {1'b0, b_reg};
    assign match     = (expected == {carry_reg, sum_reg});
    assign check_now = (state == CHECK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_count <= '0;
            fail_count <= '0;
            error      <= 1'b0;
        end else if (check_now) begin
            if (match) begin
                if (pass_count != CNT_MAX) begin
                    pass_count <= pass_count + CNT_ONE;
                end
            end else begin
                if (fail_count != CNT_MAX) begin
                    fail_count <= fail_count + CNT_ONE;
                end
                error <= 1'b1;
            end
        end
    end

`ifdef SUM_CHECK_FAIL_CAPTURE_EN
    // Capture only on the 0->1 transition of error so later mismatches
    // cannot overwrite the first failing vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_a     <= '0;
            fail_b     <= '0;
            fail_sum   <= '0;
            fail_carry <= 1'b0;
        end else if (check_now && !match && !error) begin
            fail_a     <= a_reg;
            fail_b     <= b_reg;
            fail_sum   <= sum_reg;
            fail_carry <= carry_reg;
        end
    end
`else
    assign fail_a     = '0;
    assign fail_b     = '0;
    assign fail_sum   = '0;
    assign fail_carry = 1'b0;
`endif

endmodule
